// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with grant parking and a contended-hold watchdog.
// Grants decode the registered owner (one-cycle handoff); no preemption; starve is status only.
module bus_arbiter #(
   parameter int HOLD_W   = 8,
   parameter int MAX_HOLD = 255
) (
   input  logic       clk,
   input  logic       reset_,
   input  logic       m0_req_,
   input  logic       m1_req_,
   input  logic       m2_req_,
   input  logic       m3_req_,
   output logic       m0_grnt_,
   output logic       m1_grnt_,
   output logic       m2_grnt_,
   output logic       m3_grnt_,
   output logic [1:0] owner,
   output logic       starve
);

   localparam logic [HOLD_W-1:0] MAX_CNT = HOLD_W'(MAX_HOLD);

   logic [3:0]        req;
   logic [3:0]        others;
   logic [1:0]        next_owner;
   logic              contention;
   logic [HOLD_W-1:0] hold_cnt;

   assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};

   // Only the owner giving up the bus moves the grant; search starts just past it.
   always_comb begin
      next_owner = owner;
      if (!req[owner]) begin
         if (req[owner + 2'd1])
            next_owner = owner + 2'd1;
         else if (req[owner + 2'd2])
            next_owner = owner + 2'd2;
         else if (req[owner + 2'd3])
            next_owner = owner + 2'd3;
      end
   end

   assign others     = req & ~(4'b0001 << owner);
   assign contention = req[owner] && (others != 4'b0000);

   always_ff @(posedge clk) begin
      if (!reset_) begin
         owner    <= 2'd0;
         hold_cnt <= '0;
      end else begin
         owner <= next_owner;
         if ((next_owner != owner) || !contention)
            hold_cnt <= '0;
         else if (hold_cnt != MAX_CNT)
            hold_cnt <= hold_cnt + HOLD_W'(1);
      end
   end

   assign m0_grnt_ = (owner != 2'd0);
   assign m1_grnt_ = (owner != 2'd1);
   assign m2_grnt_ = (owner != 2'd2);
   assign m3_grnt_ = (owner != 2'd3);
   assign starve   = (hold_cnt == MAX_CNT);

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboarded bench: a rule-level model predicts owner/grants/starve per cycle for two
// parameterisations (MAX_HOLD=4 and a saturating 2-bit counter) driven by the same requests.
module tb_bus_arbiter;

   logic       clk = 1'b0;
   logic       reset_ = 1'b0;
   logic [3:0] req_n = 4'b0000;

   logic       a_g0, a_g1, a_g2, a_g3, a_starve;
   logic [1:0] a_owner;
   logic       b_g0, b_g1, b_g2, b_g3, b_starve;
   logic [1:0] b_owner;

   always #5 clk = ~clk;

   bus_arbiter #(.HOLD_W(8), .MAX_HOLD(4)) dut_a (
      .clk(clk), .reset_(reset_),
      .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
      .m0_grnt_(a_g0), .m1_grnt_(a_g1), .m2_grnt_(a_g2), .m3_grnt_(a_g3),
      .owner(a_owner), .starve(a_starve)
   );

   bus_arbiter #(.HOLD_W(2), .MAX_HOLD(3)) dut_b (
      .clk(clk), .reset_(reset_),
      .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
      .m0_grnt_(b_g0), .m1_grnt_(b_g1), .m2_grnt_(b_g2), .m3_grnt_(b_g3),
      .owner(b_owner), .starve(b_starve)
   );

   typedef struct {
      int owner;
      int starve_a;
      int starve_b;
   } exp_t;

   exp_t q[$];
   int   tests  = 0;
   int   errors = 0;

   // Reference state: who owns the bus and how long the current contended run has lasted.
   int   m_owner = 0;
   int   m_run_a = 0;
   int   m_run_b = 0;
   bit   m_valid = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int grant_code(input int own);
      return 15 - (1 << own);
   endfunction

   // Apply the rules to the requests seen this cycle to get next cycle's state.
   task automatic model_step(input logic rst_n, input logic [3:0] rq_n);
      int  nxt;
      bit  own_req, other_req;
      if (!rst_n) begin
         m_owner = 0; m_run_a = 0; m_run_b = 0; m_valid = 1'b1;
         return;
      end
      if (!m_valid) return;
      own_req   = !rq_n[m_owner];
      other_req = 1'b0;
      for (int i = 0; i < 4; i++)
         if (i != m_owner && !rq_n[i]) other_req = 1'b1;
      nxt = m_owner;
      if (!own_req) begin
         for (int k = 3; k >= 1; k--)
            if (!rq_n[(m_owner + k) % 4]) nxt = (m_owner + k) % 4;
      end
      if (nxt != m_owner || !(own_req && other_req)) begin
         m_run_a = 0; m_run_b = 0;
      end else begin
         m_run_a = (m_run_a + 1 > 4) ? 4 : m_run_a + 1;
         m_run_b = (m_run_b + 1 > 3) ? 3 : m_run_b + 1;
      end
      m_owner = nxt;
   endtask

   task automatic step(input logic rst_n, input logic [3:0] rq_n);
      exp_t e;
      @(posedge clk); #1;
      if (m_valid) begin
         e.owner    = m_owner;
         e.starve_a = (m_run_a == 4) ? 1 : 0;
         e.starve_b = (m_run_b == 3) ? 1 : 0;
         q.push_back(e);
      end
      reset_ = rst_n;
      req_n  = rq_n;
      model_step(rst_n, rq_n);
   endtask

   task automatic hold(input int n, input logic [3:0] rq_n);
      for (int i = 0; i < n; i++) step(1'b1, rq_n);
   endtask

   // Monitor: outputs are valid every cycle; compare whatever the driver has queued.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("owner_a",  int'(a_owner), e.owner);
            check("grants_a", int'({a_g3, a_g2, a_g1, a_g0}), grant_code(e.owner));
            check("starve_a", int'(a_starve), e.starve_a);
            check("owner_b",  int'(b_owner), e.owner);
            check("grants_b", int'({b_g3, b_g2, b_g1, b_g0}), grant_code(e.owner));
            check("starve_b", int'(b_starve), e.starve_b);
         end
      end
   end

   initial begin : driver
      logic [3:0] r;
      step(1'b0, 4'b0000);
      step(1'b0, 4'b0000);
      hold(3, 4'b1110);            // m0 holds after reset
      hold(10, 4'b1111);           // parking on 0
      hold(3, 4'b1011);            // m2 to idle bus
      hold(2, 4'b1101);            // m1 takes over -> owner 1
      hold(3, 4'b0000);            // everyone requests, m1 keeps it
      hold(2, 4'b0010);            // m1 releases -> 2
      hold(2, 4'b0110);            // m2 releases -> 3
      hold(2, 4'b1110);            // m3 releases -> 0
      hold(3, 4'b1110);
      hold(22, 4'b0110);           // m0 vs m3 contention: watchdog and saturation
      hold(3, 4'b0111);            // m0 releases -> 3
      hold(3, 4'b0000);            // owner 3, all requesting
      step(1'b0, 4'b0000);         // mid-operation reset pulse
      hold(3, 4'b0000);
      hold(2, 4'b0001);
      hold(2, 4'b0011);
      r = 4'b1111;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 1) == 0) r = 4'($urandom_range(0, 15));
         step(($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1, r);
      end
      step(1'b1, 4'b1111);
      @(negedge clk);
      #1;
      tests++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
